// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register file slice.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/decoder_5to32.sv
// Binary-to-one-hot address decoder; one output line per register write strobe.
module decoder_5to32 #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]      a,
    output logic [2**ADDR_W-1:0]   y
);
    always_comb begin
        y = '0;
        y[a] = 1'b1;
    end
endmodule

// File: rtl/register_file_32x32_cell.sv
// register_cell: one general-purpose register with async active-high clear and load enable.
module register_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/register_file_32x32.sv
// MIPS register file, 32 x 32, one write / two combinational read ports.
// Define REGFILE_BYPASS_EN to forward Din to a read port addressing the register being written.
module register_file_32x32
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);
    localparam int N = 2**ADDR_W;

    logic [N-1:0]      degout;
    logic [DATA_W-1:0] regs [N];
    logic              wr_live;

    decoder_5to32 #(.ADDR_W(ADDR_W)) u_dec (
        .a (Awr),
        .y (degout)
    );

    // degout[0] marks a write aimed at the hardwired zero register, which never counts as live
    assign wr_live = WrEn & ~degout[0];
    assign regs[0] = '0;

    for (genvar i = 1; i < N; i++) begin : g_reg
        register_cell #(.DATA_W(DATA_W)) u_cell (
            .clk (Clk),
            .rst (Rst),
            .ld  (wr_live & degout[i]),
            .d   (Din),
            .q   (regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = wr_live & ~Rst & (Ard1 == Awr);
    assign hit2 = wr_live & ~Rst & (Ard2 == Awr);

    always_comb begin
        Dout1 = hit1 ? Din : regs[Ard1];
        Dout2 = hit2 ? Din : regs[Ard2];
    end
`else
    always_comb begin
        Dout1 = regs[Ard1];
        Dout2 = regs[Ard2];
    end
`endif
endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench for register_file_32x32: directed cases plus random traffic against an array model.
module tb_register_file_32x32;
    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  Ard1, Ard2, Awr;
    logic [31:0] Din;
    logic        WrEn;
    logic [31:0] Dout1, Dout2;

    logic [31:0] model [32];
    int total = 0;
    int bad   = 0;

    register_file_32x32 dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Ard1  (Ard1),
        .Ard2  (Ard2),
        .Awr   (Awr),
        .Din   (Din),
        .WrEn  (WrEn),
        .Dout1 (Dout1),
        .Dout2 (Dout2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0 || Rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (WrEn && a == Awr) return Din;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, apply the write rules to the model, settle past the edge.
    task automatic tick();
        @(posedge Clk);
        if (!Rst && WrEn && Awr != 5'd0) model[Awr] = Din;
        #1;
    endtask

    task automatic check_both(input string tag);
        #1;
        chk({tag, "_p1"}, Dout1, rd(Ard1));
        chk({tag, "_p2"}, Dout2, rd(Ard2));
    endtask

    initial begin
        Rst = 1'b1; WrEn = 1'b0; Awr = 5'd0; Din = 32'h0; Ard1 = 5'd5; Ard2 = 5'd31;
        clear_model();
        tick(); tick();
        #1;
        chk("rst_hold_p1", Dout1, 32'h0);
        chk("rst_hold_p2", Dout2, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;

        // 1: all addresses read zero after reset
        for (int i = 0; i < 32; i++) begin
            Ard1 = 5'(i); Ard2 = 5'(31 - i);
            #1;
            chk("reset_p1", Dout1, 32'h0);
            chk("reset_p2", Dout2, 32'h0);
        end

        // 2: single write to reg 8; first edge after reset release takes it
        Awr = 5'd8; Din = 32'hDEAD_BEEF; WrEn = 1'b1;
        tick();
        WrEn = 1'b0; Ard1 = 5'd8; Ard2 = 5'd9;
        #1;
        chk("w8_p1", Dout1, 32'hDEAD_BEEF);
        chk("w8_p2", Dout2, 32'h0);

        // 3: writes to reg 0 are discarded and never bypassed
        Awr = 5'd0; Din = 32'hFFFF_FFFF; WrEn = 1'b1; Ard1 = 5'd0; Ard2 = 5'd0;
        #1;
        chk("r0_same_cycle", Dout1, 32'h0);
        tick();
        WrEn = 1'b0;
        #1;
        chk("r0_after_edge", Dout1, 32'h0);
        chk("r0_after_edge_p2", Dout2, 32'h0);

        // 4: fill 1..31, read complementary pairs, then idle edges must change nothing
        for (int i = 1; i < 32; i++) begin
            Awr = 5'(i); Din = 32'h100 + 32'(i); WrEn = 1'b1;
            tick();
        end
        WrEn = 1'b0;
        for (int i = 1; i < 32; i++) begin
            Ard1 = 5'(i); Ard2 = 5'(32 - i);
            #1;
            chk("fill_p1", Dout1, 32'h100 + 32'(i));
            chk("fill_p2", Dout2, 32'h100 + 32'(32 - i));
        end
        Din = 32'h0;
        for (int k = 0; k < 5; k++) begin
            Awr = (k == 0) ? 5'bx : 5'($urandom_range(1, 31));
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            Ard1 = 5'(i); Ard2 = 5'(i);
            #1;
            chk("idle_p1", Dout1, 32'h100 + 32'(i));
            chk("idle_p2", Dout2, 32'h100 + 32'(i));
        end

        // 5: read/write collision on reg 17
        Awr = 5'd17; Din = 32'hA5A5_A5A5; WrEn = 1'b1;
        tick();
        Din = 32'h1234_5678; Ard1 = 5'd17; Ard2 = 5'd16;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("coll_before", Dout1, 32'h1234_5678);
`else
        chk("coll_before", Dout1, 32'hA5A5_A5A5);
`endif
        chk("coll_other", Dout2, 32'h110);
        tick();
        WrEn = 1'b0;
        #1;
        chk("coll_after", Dout1, 32'h1234_5678);

        // 6: async reset between edges, and a write coinciding with reset is lost
        Awr = 5'd3; Din = 32'h0000_00FF; WrEn = 1'b1;
        tick();
        WrEn = 1'b0; Ard1 = 5'd3; Ard2 = 5'd8;
        #1;
        chk("r3_written", Dout1, 32'h0000_00FF);
        #2;
        Rst = 1'b1; clear_model();
        #1;
        chk("async_rst_r3", Dout1, 32'h0);
        chk("async_rst_r8", Dout2, 32'h0);
        Awr = 5'd3; Din = 32'h0BAD_F00D; WrEn = 1'b1;
        tick();
        @(negedge Clk);
        Rst = 1'b0; WrEn = 1'b0;
        #1;
        chk("write_in_rst_lost", Dout1, 32'h0);

        // random traffic with occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            Ard1 = 5'($urandom_range(0, 31));
            Ard2 = ($urandom_range(0, 3) == 0) ? Ard1 : 5'($urandom_range(0, 31));
            Awr  = ($urandom_range(0, 3) == 0) ? Ard1 : 5'($urandom_range(0, 31));
            Din  = $urandom;
            WrEn = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) begin
                Rst = 1'b1; clear_model();
            end
            check_both("rand_pre");
            tick();
            Rst = 1'b0;
            check_both("rand_post");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
